// File: rtl/kernel_a_drain_if.sv
// kernel_a_drain_if: upstream accept, kernel result and buffered-output handshake bundle.
interface kernel_a_drain_if #(parameter int DATAW = 32) ();
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [DATAW-1:0] kv_data;
  logic             stall;
  logic [DATAW-1:0] out_data;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;
  modport slave (input in_valid, in_last, kv_data, out_ready,
                 output in_ready, stall, out_data, out_last, out_valid);
  modport master (output in_valid, in_last, kv_data, out_ready,
                  input in_ready, stall, out_data, out_last, out_valid);
endinterface

// File: rtl/kernel_a_drain.sv
// kernel_a_drain: tags kernel_A results through its pipeline, buffers them in a FWFT FIFO and sequences stream drain.
// Optional word counter enabled by defining KERNEL_A_DRAIN_WCNT_EN.
module kernel_a_drain #(
  parameter int DATAW      = 32,
  parameter int PIPE_LAT   = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  kernel_a_drain_if.slave io,
  output logic          done,
  output logic [CW-1:0] count,
  output logic [31:0]   word_cnt
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  logic [1:0]          state_q, state_d;
  logic [PIPE_LAT-1:0] vld_q, vld_d, lst_q, lst_d;
  logic [AW-1:0]       wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]       count_q, count_d;
  logic [DATAW:0]      mem_q [FIFO_DEPTH];
  logic                accept, wr, pop;
  always_comb begin
    io.stall     = count_q == CW'(FIFO_DEPTH);
    io.in_ready  = !io.stall && (state_q == IDLE || state_q == RUN);
    accept       = io.in_valid && io.in_ready;
    wr           = !io.stall && vld_q[PIPE_LAT-1];
    io.out_valid = count_q != '0;
    io.out_data  = mem_q[rp_q][DATAW-1:0];
    io.out_last  = io.out_valid && mem_q[rp_q][DATAW];
    pop          = io.out_valid && io.out_ready;
    vld_d        = io.stall ? vld_q : (vld_q << 1) | PIPE_LAT'(accept);
    lst_d        = io.stall ? lst_q : (lst_q << 1) | PIPE_LAT'(accept && io.in_last);
    wp_d         = wp_q + AW'(wr);
    rp_d         = rp_q + AW'(pop);
    count_d      = count_q + CW'(wr) - CW'(pop);
    state_d      = state_q == DONE  ? IDLE :
                   state_q == DRAIN ? (pop && io.out_last ? DONE : DRAIN) :
                   accept           ? (io.in_last ? DRAIN : RUN) : state_q;
    done         = state_q == DONE;
    count        = count_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      vld_q   <= '0;
      lst_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      lst_q   <= lst_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end
  // Storage needs no reset: out_valid/out_last are gated by count.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q] <= {lst_q[PIPE_LAT-1], io.kv_data};
  end
`ifdef KERNEL_A_DRAIN_WCNT_EN
  logic [31:0] wcnt_q, wcnt_d;
  always_comb wcnt_d = state_q == DONE ? '0 : wcnt_q + 32'(pop);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wcnt_q <= '0;
    else wcnt_q <= wcnt_d;
  end
  assign word_cnt = wcnt_q;
`else
  assign word_cnt = '0;
`endif
endmodule

// File: doc/kernel_a_drain.md
KERNEL_A_DRAIN -- requirements
Module: kernel_a_drain

Interface
REQ-001 Parameter: DATAW, 32, width of kernel result and output data.
REQ-002 Parameter: PIPE_LAT, 4, kernel pipeline latency in non-stalled cycles (>=1).
REQ-003 Parameter: FIFO_DEPTH, 8, output buffer entries (power of two, >=2).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-006 in_valid  in  1  upstream source presents an operand pair to the kernel this cycle.
REQ-007 in_last  in  1  qualifies in_valid; marks the final element of the stream.
REQ-008 in_ready  out  1  upstream pair accepted when in_valid & in_ready.
REQ-009 kv_data  in  DATAW  kernel result, ka_vout of kernel_A.
REQ-010 stall  out  1  freeze kernel pipeline and upstream source.
REQ-011 out_data  out  DATAW  buffered result.
REQ-012 out_last  out  1  out_data is the final element.
REQ-013 out_valid  out  1  out_data/out_last valid.
REQ-014 out_ready  in  1  consumer takes word when out_valid & out_ready.
REQ-015 done  out  1  one-cycle pulse after the final element leaves.
REQ-016 count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-017 word_cnt  out  32  words delivered in current stream (see Configuration).

Function
REQ-018 stall SHALL equal (count == FIFO_DEPTH), combinational from registered count only.
REQ-019 accept SHALL be in_valid & in_ready; in_ready = !stall & (state is IDLE or RUN).
REQ-020 Valid and last tags SHALL travel a PIPE_LAT-stage shift register advancing only when stall=0; stage 0 loads accept and accept&in_last.
REQ-021 When stall=0 and final tag stage is valid, kv_data and final last tag SHALL be written to the FIFO that cycle.
REQ-022 When stall=1 the tag register SHALL hold and no FIFO write SHALL occur.
REQ-023 FIFO SHALL be first-word-fall-through: out_valid = (count != 0), out_data/out_last show head entry.
REQ-024 Simultaneous write and pop SHALL leave count unchanged; pop at count=FIFO_DEPTH SHALL deassert stall next cycle.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH without loss or duplication.
REQ-026 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-027 IDLE->RUN on accept with in_last=0; IDLE or RUN->DRAIN on accept with in_last=1.
REQ-028 DRAIN->DONE on the cycle the out_last=1 word is popped; in_ready=0 throughout DRAIN and DONE.
REQ-029 DONE SHALL assert done for exactly one cycle and return to IDLE next cycle.
REQ-030 A single-element stream (first accept has in_last=1) SHALL go IDLE->DRAIN directly.
REQ-031 Latency: result of an accepted pair SHALL appear at out_valid PIPE_LAT+1 non-stalled cycles after accept when FIFO empty.

Reset
REQ-032 While rst=0: state=IDLE, tag register cleared, pointers and count=0, out_valid=0, out_last=0, stall=0, in_ready=1, done=0, word_cnt=0.
REQ-033 Reset asserted mid-stream SHALL discard all in-flight tags and FIFO contents immediately; out_data content is don't-care.

Configuration
REQ-034 Macro KERNEL_A_DRAIN_WCNT_EN defined: word_cnt increments on every pop, wraps at 2^32, clears on entry to IDLE from DONE.
REQ-035 Macro undefined: word_cnt SHALL be constant 0 and the counter SHALL not be synthesised.

Verification
REQ-036 Reset, 5 accepts (last on 5th), out_ready=1, kv_data=10..14 -> outputs 10..14, out_last on 14, done pulses once, word_cnt=5 (macro on).
REQ-037 out_ready=0, 12 back-to-back accepts -> count reaches 8, stall=1, in_ready=0, no write beyond 8; then out_ready=1 -> 12 words in order, none lost.
REQ-038 Single accept with in_last=1, kv_data=0xDEADBEEF -> state DRAIN next cycle, out_valid after 5 cycles with out_last=1, done follows pop.
REQ-039 FIFO at 8 with pop and tag-valid same cycle -> stall=1 blocks write that cycle, count=7 next cycle, write proceeds after.
REQ-040 rst=0 pulse with count=5 and 3 tags in flight -> count=0, out_valid=0, stall=0, state IDLE; no stale word emerges afterwards.
REQ-041 In DRAIN, in_valid=1 held -> in_ready=0, no tag inserted, output stream ends at the marked last word.
